// File: rtl/dvl_pkg.sv
// rtl/dvl_pkg.sv - DVL shared types: bridge state, burst FSM states, gate vectors
package dvl_pkg;

   typedef enum logic [1:0] {
      HIGHZ = 2'd0,
      DAMP  = 2'd1,
      OSCL  = 2'd2
   } h_bridge_state_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OSC  = 2'd1,
      DMP  = 2'd2
   } h_bridge_fsm_t;

   // Gate vector bit order: {hlh, hll, hrh, hrl}
   typedef logic [3:0] gate_vec_t;

   localparam gate_vec_t GATES_OFF = 4'b0000;
   localparam gate_vec_t GATES_A   = 4'b1001;
   localparam gate_vec_t GATES_B   = 4'b0110;
   localparam gate_vec_t GATES_DMP = 4'b0101;

endpackage

// File: rtl/h_bridge_burst_if.sv
// rtl/h_bridge_burst_if.sv - sequencer-side handshake and burst configuration bundle
interface h_bridge_burst_if
   import dvl_pkg::*;
#(
   parameter int DIV_W  = 16,
   parameter int CNT_W  = 12,
   parameter int DAMP_W = 16,
   parameter int DT_W   = 4
);
   logic              start;
   logic              abort;
   logic [DIV_W-1:0]  half_period;
   logic [CNT_W-1:0]  n_cycles;
   logic [DAMP_W-1:0] damp_len;
   logic [DT_W-1:0]   deadtime;
   logic              busy;
   logic              done;
   h_bridge_state_t   state_o;

   modport master (
      output start, abort, half_period, n_cycles, damp_len, deadtime,
      input  busy, done, state_o
   );

   modport slave (
      input  start, abort, half_period, n_cycles, damp_len, deadtime,
      output busy, done, state_o
   );
endinterface

// File: rtl/h_bridge_deadtime.sv
// rtl/h_bridge_deadtime.sv - blanks all gates for the first T clocks of each switching segment
module h_bridge_deadtime
   import dvl_pkg::*;
#(
   parameter int DT_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            seg_start,
   input  logic [DT_W-1:0] t,
   input  gate_vec_t       req,
   output gate_vec_t       gates
);
   logic [DT_W-1:0] rem_q;

   // rem_q counts blanked clocks still owed after the current one
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_q <= '0;
         gates <= GATES_OFF;
      end else if (seg_start) begin
         if (t != '0) begin
            gates <= GATES_OFF;
            rem_q <= t - DT_W'(1);
         end else begin
            gates <= req;
            rem_q <= '0;
         end
      end else if (rem_q != '0) begin
         gates <= GATES_OFF;
         rem_q <= rem_q - DT_W'(1);
      end else begin
         gates <= req;
      end
   end
endmodule

// File: rtl/h_bridge_burst.sv
// rtl/h_bridge_burst.sv - H-bridge square-wave burst driver with damping tail
// Optional dead-time blanking at every switching event: H_BRIDGE_DEADTIME_EN
module h_bridge_burst
   import dvl_pkg::*;
#(
   parameter int DIV_W  = 16,
   parameter int CNT_W  = 12,
   parameter int DAMP_W = 16,
   parameter int DT_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   h_bridge_burst_if.slave  seq,
   output logic             hlh,
   output logic             hll,
   output logic             hrh,
   output logic             hrl
);
   localparam int HC_W = CNT_W + 1;

   h_bridge_fsm_t     fsm_q, fsm_d;
   logic              phase_q, phase_d;
   logic [DIV_W-1:0]  div_q, div_d, p_q, p_d;
   logic [HC_W-1:0]   half_q, half_d;
   logic [DAMP_W-1:0] damp_q, damp_d, d_q, d_d;
   logic              done_d, seg_start;
   logic              busy_q, done_q;
   h_bridge_state_t   state_q, state_d;
   gate_vec_t         req_d, gates;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q   <= IDLE;
         phase_q <= 1'b0;
         div_q   <= '0;
         half_q  <= '0;
         damp_q  <= '0;
         p_q     <= DIV_W'(1);
         d_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         state_q <= HIGHZ;
      end else begin
         fsm_q   <= fsm_d;
         phase_q <= phase_d;
         div_q   <= div_d;
         half_q  <= half_d;
         damp_q  <= damp_d;
         p_q     <= p_d;
         d_q     <= d_d;
         busy_q  <= (fsm_d != IDLE);
         done_q  <= done_d;
         state_q <= state_d;
      end
   end

   always_comb begin
      fsm_d     = fsm_q;
      phase_d   = phase_q;
      div_d     = div_q;
      half_d    = half_q;
      damp_d    = damp_q;
      p_d       = p_q;
      d_d       = d_q;
      done_d    = 1'b0;
      seg_start = 1'b0;
      case (fsm_q)
         IDLE: begin
            if (seq.start && !seq.abort) begin
               p_d = (seq.half_period == '0) ? DIV_W'(1) : seq.half_period;
               d_d = seq.damp_len;
               if (seq.n_cycles != '0) begin
                  fsm_d     = OSC;
                  phase_d   = 1'b0;
                  div_d     = p_d - DIV_W'(1);
                  half_d    = {seq.n_cycles, 1'b0} - HC_W'(1);
                  seg_start = 1'b1;
               end else if (seq.damp_len != '0) begin
                  fsm_d     = DMP;
                  damp_d    = seq.damp_len - DAMP_W'(1);
                  seg_start = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         OSC: begin
            if (seq.abort || (div_q == '0 && half_q == '0)) begin
               if (d_q != '0) begin
                  fsm_d     = DMP;
                  damp_d    = d_q - DAMP_W'(1);
                  seg_start = 1'b1;
               end else begin
                  fsm_d  = IDLE;
                  done_d = 1'b1;
               end
            end else if (div_q == '0) begin
               half_d    = half_q - HC_W'(1);
               phase_d   = ~phase_q;
               div_d     = p_q - DIV_W'(1);
               seg_start = 1'b1;
            end else begin
               div_d = div_q - DIV_W'(1);
            end
         end
         DMP: begin
            if (seq.abort || damp_q == '0) begin
               fsm_d  = IDLE;
               done_d = 1'b1;
            end else begin
               damp_d = damp_q - DAMP_W'(1);
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   // Outputs are registered from the next-state view so they line up with the state register
   always_comb begin
      req_d   = GATES_OFF;
      state_d = HIGHZ;
      case (fsm_d)
         OSC: begin
            req_d   = phase_d ? GATES_B : GATES_A;
            state_d = OSCL;
         end
         DMP: begin
            req_d   = GATES_DMP;
            state_d = DAMP;
         end
         default: ;
      endcase
   end

`ifdef H_BRIDGE_DEADTIME_EN
   logic [DT_W-1:0] t_q, t_d, t_eff;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) t_q <= '0;
      else      t_q <= t_d;
   end

   // Blanking is clamped so a phase always gets at least one driven clock
   always_comb begin
      t_d   = (fsm_q == IDLE && seq.start && !seq.abort) ? seq.deadtime : t_q;
      t_eff = t_d;
      if (fsm_d == OSC && DIV_W'(t_d) > p_d - DIV_W'(1))
         t_eff = DT_W'(p_d - DIV_W'(1));
      else if (fsm_d == DMP && DAMP_W'(t_d) > d_d)
         t_eff = DT_W'(d_d);
   end

   h_bridge_deadtime #(.DT_W(DT_W)) u_deadtime (
      .clk       (clk),
      .rst       (rst),
      .seg_start (seg_start),
      .t         (t_eff),
      .req       (req_d),
      .gates     (gates)
   );
`else
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) gates <= GATES_OFF;
      else      gates <= req_d;
   end
`endif

   assign {hlh, hll, hrh, hrl} = gates;
   assign seq.busy    = busy_q;
   assign seq.done    = done_q;
   assign seq.state_o = state_q;
endmodule

// File: tb/tb_h_bridge_burst.sv
// tb/tb_h_bridge_burst.sv - directed self-checking bench for h_bridge_burst
module tb_h_bridge_burst;
   import dvl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic hlh, hll, hrh, hrl;
   logic [3:0] g;
   int vectors = 0;
   int errors  = 0;

   h_bridge_burst_if #(.DIV_W(16), .CNT_W(12), .DAMP_W(16), .DT_W(4)) seq ();

   h_bridge_burst #(.DIV_W(16), .CNT_W(12), .DAMP_W(16), .DT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .seq (seq),
      .hlh (hlh),
      .hll (hll),
      .hrh (hrh),
      .hrl (hrl)
   );

   always #5 clk = ~clk;
   assign g = {hlh, hll, hrh, hrl};

   always @(negedge clk) begin
      vectors++;
      if ((hlh && hll) || (hrh && hrl)) begin
         errors++;
         $display("FAIL shoot_through t=%0t gates=%b required no same-side pair", $time, g);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   // Expected {done, busy, state, gates} for cycle i after the start edge
   function automatic logic [7:0] model(int i, int p, int n, int d, int t);
      int pe, te, tot, off;
      logic [1:0] st;
      logic [3:0] gv;
      pe  = (p == 0) ? 1 : p;
`ifndef H_BRIDGE_DEADTIME_EN
      t = 0;
`endif
      tot = 2 * n * pe + d;
      if (i < 2 * n * pe) begin
         off = i % pe;
         te  = (t > pe - 1) ? pe - 1 : t;
         st  = OSCL;
         gv  = (off < te) ? 4'b0000 : (((i / pe) % 2 == 0) ? 4'b1001 : 4'b0110);
         return {1'b0, 1'b1, st, gv};
      end else if (i < tot) begin
         off = i - 2 * n * pe;
         te  = (t > d) ? d : t;
         st  = DAMP;
         gv  = (off < te) ? 4'b0000 : 4'b0101;
         return {1'b0, 1'b1, st, gv};
      end
      st = HIGHZ;
      return {(i == tot), 1'b0, st, 4'b0000};
   endfunction

   task automatic idle_inputs();
      seq.start = 1'b0; seq.abort = 1'b0;
      seq.half_period = '0; seq.n_cycles = '0; seq.damp_len = '0; seq.deadtime = '0;
   endtask

   task automatic pulse_start(input int p, input int n, input int d, input int t);
      @(posedge clk); #1;
      seq.half_period = 16'(p); seq.n_cycles = 12'(n);
      seq.damp_len = 16'(d); seq.deadtime = 4'(t);
      seq.start = 1'b1;
      @(posedge clk); #1;
      seq.start = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({seq.done, seq.busy, seq.state_o, g} !== 8'h00) begin
         errors++;
         $display("FAIL reset_state got=%b required=%b", {seq.done, seq.busy, seq.state_o, g}, 8'h00);
      end
      @(posedge clk); #1 rst = 1'b1;
   endtask

   task automatic run_model(input string name, input int p, input int n, input int d, input int t, input int cycles);
      logic [7:0] got, exp;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         exp = model(i, p, n, d, t);
         got = {seq.done, seq.busy, seq.state_o, g};
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got=%b required=%b", name, i, got, exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_burst();
      int t;
`ifdef H_BRIDGE_DEADTIME_EN
      t = 0;
`else
      t = 7;
`endif
      pulse_start(32, 4, 10, t);
      run_model("burst_p32_n4_d10", 32, 4, 10, t, 268);
   endtask

`ifdef H_BRIDGE_DEADTIME_EN
   task automatic test_deadtime();
      pulse_start(8, 2, 6, 3);
      run_model("deadtime_p8_n2_t3_d6", 8, 2, 6, 3, 40);
   endtask
`endif

   task automatic test_abort();
      logic [7:0] got, exp;
      logic [1:0] st;
      int dones = 0;
      pulse_start(5, 10, 8, 0);
      for (int i = 0; i < 30; i++) begin
         seq.abort = (i == 17);
         @(negedge clk);
         if (i <= 17) exp = model(i, 5, 10, 8, 0);
         else if (i < 26) begin st = DAMP; exp = {2'b01, st, 4'b0101}; end
         else begin st = HIGHZ; exp = {(i == 26), 1'b0, st, 4'b0000}; end
         got = {seq.done, seq.busy, seq.state_o, g};
         if (seq.done) dones++;
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL abort_osc cycle %0d got=%b required=%b", i, got, exp);
         end
         @(posedge clk); #1;
      end
      seq.abort = 1'b0;
      vectors++;
      if (dones !== 1) begin
         errors++;
         $display("FAIL abort_done_count got=%0d required=1", dones);
      end
      pulse_start(5, 1, 8, 0);
      for (int i = 0; i < 15; i++) begin
         seq.abort = (i == 12);
         @(negedge clk);
         if (i <= 12) exp = model(i, 5, 1, 8, 0);
         else begin st = HIGHZ; exp = {(i == 13), 1'b0, st, 4'b0000}; end
         got = {seq.done, seq.busy, seq.state_o, g};
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL abort_dmp cycle %0d got=%b required=%b", i, got, exp);
         end
         @(posedge clk); #1;
      end
      seq.abort = 1'b0;
   endtask

   task automatic test_zero_len();
      pulse_start(4, 0, 0, 0);
      run_model("zero_len", 4, 0, 0, 0, 3);
   endtask

   task automatic test_start_abort();
      @(posedge clk); #1;
      seq.half_period = 16'd4; seq.n_cycles = 12'd2; seq.damp_len = 16'd3;
      seq.start = 1'b1; seq.abort = 1'b1;
      @(posedge clk); #1;
      seq.start = 1'b0; seq.abort = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vectors++;
         if ({seq.done, seq.busy, seq.state_o, g} !== 8'h00) begin
            errors++;
            $display("FAIL start_abort cycle %0d got=%b required=%b", i, {seq.done, seq.busy, seq.state_o, g}, 8'h00);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] got, exp;
      pulse_start(3, 2, 2, 0);
      for (int i = 0; i < 16; i++) begin
         seq.start = (i >= 2 && i <= 5);
         if (i == 2) begin seq.half_period = 16'd9; seq.n_cycles = 12'd7; seq.damp_len = 16'd5; end
         @(negedge clk);
         exp = model(i, 3, 2, 2, 0);
         got = {seq.done, seq.busy, seq.state_o, g};
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL start_while_busy cycle %0d got=%b required=%b", i, got, exp);
         end
         @(posedge clk); #1;
      end
      seq.start = 1'b0;
   endtask

   task automatic test_reset_mid();
      pulse_start(32, 4, 10, 0);
      repeat (10) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      vectors++;
      if ({seq.busy, seq.state_o, g} !== 7'h00) begin
         errors++;
         $display("FAIL async_reset got=%b required=%b", {seq.busy, seq.state_o, g}, 7'h00);
      end
      @(posedge clk); #1 rst = 1'b1;
      pulse_start(2, 1, 1, 0);
      run_model("after_reset", 2, 1, 1, 0, 7);
   endtask

   initial begin
      test_reset();
      test_burst();
`ifdef H_BRIDGE_DEADTIME_EN
      test_deadtime();
`endif
      test_abort();
      test_zero_len();
      test_start_abort();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
